// File: rtl/burst_mem_responder_pkg.sv
// rtl/burst_mem_responder_pkg.sv - shared burst memory constants and FSM state type
package bmem_pkg;

  localparam int BMEM_BEATS    = 4;
  localparam int BMEM_BEAT_W   = 64;
  localparam int BMEM_LINE_W   = BMEM_BEATS * BMEM_BEAT_W;
  localparam int BMEM_OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } bmem_state_t;

endpackage

// File: rtl/burst_mem_responder_if.sv
// rtl/burst_mem_responder_if.sv - 4-beat burst memory bus between adaptor and memory
interface burst_mem_responder_if;
  import bmem_pkg::*;

  logic [31:0]            bmem_address;
  logic                   bmem_read;
  logic                   bmem_write;
  logic [BMEM_BEAT_W-1:0] bmem_wdata;
  logic [BMEM_BEAT_W-1:0] bmem_rdata;
  logic                   bmem_resp;

  modport master (
    output bmem_address, bmem_read, bmem_write, bmem_wdata,
    input  bmem_rdata, bmem_resp
  );

  modport slave (
    input  bmem_address, bmem_read, bmem_write, bmem_wdata,
    output bmem_rdata, bmem_resp
  );

endinterface

// File: rtl/burst_mem_responder_line_store.sv
// rtl/burst_mem_responder_line_store.sv - beat-addressed line array, registered read, one write port
module bmem_line_store
  import bmem_pkg::*;
#(
  parameter int LINES  = 256,
  parameter int ADDR_W = $clog2(LINES) + 2
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [BMEM_BEAT_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [BMEM_BEAT_W-1:0] rdata
);

  // No reset on the array: contents must survive rst.
  logic [BMEM_BEAT_W-1:0] mem [LINES*BMEM_BEATS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - burst memory responder: latency, 4-beat transfer, protocol checker
module burst_mem_responder
  import bmem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int LINES   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  burst_mem_responder_if.slave   bmem,
  output logic                   proto_err
);

  localparam int IDX_W = $clog2(LINES);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  bmem_state_t state, state_d;
  logic [7:0]       lat_cnt, lat_cnt_d;
  logic [1:0]       beat_cnt, beat_cnt_d;
  logic [IDX_W-1:0] line_q, line_d;
  logic             op_read_q, op_read_d;
  logic             resp_q;
  logic             proto_err_d;
  logic             viol;
  logic             burst_we;

  logic [IDX_W-1:0]       req_line;
  logic [IDX_W-1:0]       rd_line;
  logic [1:0]             rd_beat;
  logic [IDX_W+1:0]       st_raddr;
  logic [IDX_W+1:0]       st_waddr;
  logic [BMEM_BEAT_W-1:0] st_rdata;
  logic                   unused_addr_bits;

  assign req_line         = bmem.bmem_address[BMEM_OFFSET_W +: IDX_W];
  assign unused_addr_bits = ^{bmem.bmem_address[31:BMEM_OFFSET_W+IDX_W],
                              bmem.bmem_address[BMEM_OFFSET_W-1:0]};

  // The latched op's request must stay up and the other one down.
  assign viol = op_read_q ? (!bmem.bmem_read  || bmem.bmem_write)
                          : (!bmem.bmem_write || bmem.bmem_read);

  always_comb begin
    state_d     = state;
    lat_cnt_d   = lat_cnt;
    beat_cnt_d  = beat_cnt;
    line_d      = line_q;
    op_read_d   = op_read_q;
    proto_err_d = proto_err;
    burst_we    = 1'b0;
    unique case (state)
      IDLE: begin
        beat_cnt_d = 2'd0;
        if (bmem.bmem_read || bmem.bmem_write) begin
          line_d    = req_line;
          op_read_d = bmem.bmem_read;
          lat_cnt_d = LAT_LOAD;
          if (bmem.bmem_read && bmem.bmem_write) begin
            proto_err_d = 1'b1;
          end
          state_d = (LATENCY == 1) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (viol) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else if (lat_cnt <= 8'd1) begin
          state_d = BURST;
        end else begin
          lat_cnt_d = lat_cnt - 8'd1;
        end
      end
      BURST: begin
        if (viol) begin
          proto_err_d = 1'b1;
          beat_cnt_d  = 2'd0;
          state_d     = IDLE;
        end else begin
          burst_we   = !op_read_q;
          beat_cnt_d = beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= 8'd0;
      beat_cnt  <= 2'd0;
      line_q    <= '0;
      op_read_q <= 1'b1;
      resp_q    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_d;
      lat_cnt   <= lat_cnt_d;
      beat_cnt  <= beat_cnt_d;
      line_q    <= line_d;
      op_read_q <= op_read_d;
      resp_q    <= (state_d == BURST);
      proto_err <= proto_err_d;
    end
  end

  // Prefetch the beat that will be on the bus next cycle so rdata lines up with resp.
  assign rd_line  = (state == IDLE) ? req_line : line_q;
  assign rd_beat  = (state == BURST) ? beat_cnt + 2'd1 : 2'd0;
  assign st_raddr = {rd_line, rd_beat};
  assign st_waddr = {line_q, beat_cnt};

  bmem_line_store #(
    .LINES  (LINES),
    .ADDR_W (IDX_W + 2)
  ) u_store (
    .clk   (clk),
    .we    (burst_we && !rst),
    .waddr (st_waddr),
    .wdata (bmem.bmem_wdata),
    .raddr (st_raddr),
    .rdata (st_rdata)
  );

  assign bmem.bmem_resp  = resp_q;
  assign bmem.bmem_rdata = resp_q ? st_rdata : '0;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - directed and random checks of burst_mem_responder against a line model
module tb_burst_mem_responder;

  logic clk;
  logic rst;
  logic perr0;
  logic perr1;

  burst_mem_responder_if if0();
  burst_mem_responder_if if1();

  burst_mem_responder #(.LATENCY(4), .LINES(256)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .bmem      (if0),
    .proto_err (perr0)
  );

  burst_mem_responder #(.LATENCY(1), .LINES(256)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bmem      (if1),
    .proto_err (perr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [255:0] model0 [256];
  logic [255:0] model1 [256];
  int           wq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lidx(input logic [31:0] addr);
    return int'((addr >> 5) % 256);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [63:0] wd);
    if (sel == 0) begin
      if0.bmem_read = rd; if0.bmem_write = wr; if0.bmem_address = a; if0.bmem_wdata = wd;
    end else begin
      if1.bmem_read = rd; if1.bmem_write = wr; if1.bmem_address = a; if1.bmem_wdata = wd;
    end
  endtask

  function automatic logic get_resp(input int sel);
    return (sel == 0) ? if0.bmem_resp : if1.bmem_resp;
  endfunction

  function automatic logic [63:0] get_rdata(input int sel);
    return (sel == 0) ? if0.bmem_rdata : if1.bmem_rdata;
  endfunction

  function automatic logic get_perr(input int sel);
    return (sel == 0) ? perr0 : perr1;
  endfunction

  // Starts #1 after a rising edge with the DUT idle; leaves it idle #1 after an edge.
  task automatic xfer(input int sel, input bit is_wr, input bit both, input logic [31:0] addr,
                      input logic [255:0] wline, input logic [255:0] exp_line, input string tag);
    int  lat;
    bit  exp_r;
    lat = (sel == 0) ? 4 : 1;
    drive(sel, !is_wr || both, is_wr || both, addr, wline[63:0]);
    @(negedge clk);
    chk($sformatf("%s_accept_resp", tag), 64'(get_resp(sel)), 64'd0);
    @(posedge clk); #1;
    if (both) drive(sel, 1, 0, addr, 64'd0);
    for (int k = 1; k <= lat + 4; k++) begin
      @(negedge clk);
      exp_r = (k >= lat) && (k <= lat + 3);
      chk($sformatf("%s_resp_c%0d", tag, k), 64'(get_resp(sel)), 64'(exp_r));
      if (exp_r && !is_wr)
        chk($sformatf("%s_rdata_b%0d", tag, k - lat), get_rdata(sel), exp_line[64*(k-lat) +: 64]);
      if (k == lat + 4)
        chk($sformatf("%s_done_rdata", tag), get_rdata(sel), 64'd0);
      @(posedge clk); #1;
      if (k == lat + 3) drive(sel, 0, 0, addr, 64'd0);
      else if (k >= lat && is_wr) drive(sel, 0, 1, addr, wline[64*(k-lat+1) +: 64]);
    end
  endtask

  task automatic wr_line(input int sel, input logic [31:0] addr, input logic [255:0] line,
                         input string tag);
    xfer(sel, 1'b1, 1'b0, addr, line, 256'd0, tag);
    if (sel == 0) model0[lidx(addr)] = line;
    else          model1[lidx(addr)] = line;
  endtask

  task automatic rd_line(input int sel, input logic [31:0] addr, input string tag);
    logic [255:0] e;
    e = (sel == 0) ? model0[lidx(addr)] : model1[lidx(addr)];
    xfer(sel, 1'b0, 1'b0, addr, 256'd0, e, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [255:0] ln;
    logic [255:0] oldl;
    logic [31:0]  a;
    int           idx;
    bit           exp_r;

    rst = 1'b1;
    drive(0, 0, 0, 32'd0, 64'd0);
    drive(1, 0, 0, 32'd0, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp0", 64'(if0.bmem_resp), 64'd0);
    chk("rst_rdata0", if0.bmem_rdata, 64'd0);
    chk("rst_perr0", 64'(perr0), 64'd0);
    chk("rst_resp1", 64'(if1.bmem_resp), 64'd0);
    chk("rst_perr1", 64'(perr1), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed line write/read at 0x40.
    ln = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    wr_line(0, 32'h0000_0040, ln, "wr40");
    rd_line(0, 32'h0000_0040, "rd40");
    chk("perr_after_legal", 64'(perr0), 64'd0);

    // Aliasing and unaligned address.
    wr_line(0, 32'h0000_2040, rnd_line(), "wr2040");
    rd_line(0, 32'h0000_0040, "rd40_alias");
    rd_line(0, 32'h0000_0047, "rd47");

    // Random writes then random-alias reads of written lines.
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      wr_line(0, a, rnd_line(), $sformatf("rndwr%0d", i));
      wq.push_back(lidx(a));
    end
    for (int i = 0; i < 6; i++) begin
      idx = wq[$urandom_range(0, wq.size() - 1)];
      a = ($urandom & 32'hFFFF_E000) | (32'(idx) << 5) | 32'($urandom_range(0, 31));
      rd_line(0, a, $sformatf("rndrd%0d", i));
    end
    chk("perr_after_random", 64'(perr0), 64'd0);

    // Read and write together at accept: serviced as read, store unchanged.
    xfer(0, 1'b0, 1'b1, 32'h0000_0040, 256'd0, model0[2], "both");
    chk("perr_both", 64'(perr0), 64'd1);
    rd_line(0, 32'h0000_0040, "rd40_after_both");
    chk("perr_sticky_both", 64'(perr0), 64'd1);
    do_reset();
    chk("perr_cleared", 64'(perr0), 64'd0);

    // Read dropped after beat 1.
    drive(0, 1, 0, 32'h0000_0040, 64'd0);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1 drive(0, 0, 0, 32'h0000_0040, 64'd0);
    @(posedge clk); #1;
    chk("drop_resp", 64'(if0.bmem_resp), 64'd0);
    chk("drop_perr", 64'(perr0), 64'd1);
    chk("drop_rdata", if0.bmem_rdata, 64'd0);
    rd_line(0, 32'h0000_0040, "rd_after_drop");
    chk("drop_perr_sticky", 64'(perr0), 64'd1);
    do_reset();
    chk("drop_perr_cleared", 64'(perr0), 64'd0);

    // Reset during beat 2 of a write.
    oldl = rnd_line();
    wr_line(0, 32'h0000_0060, oldl, "wr60_old");
    ln = rnd_line();
    drive(0, 0, 1, 32'h0000_0060, ln[63:0]);
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k >= 4) drive(0, 0, 1, 32'h0000_0060, ln[64*(k-3) +: 64]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 32'd0, 64'd0);
    chk("rstmid_resp", 64'(if0.bmem_resp), 64'd0);
    model0[3] = {oldl[255:128], ln[127:0]};
    rd_line(0, 32'h0000_0060, "rd60_partial");

    // LATENCY=1 responder.
    wr_line(1, 32'h0000_0080, rnd_line(), "l1_wr80");
    rd_line(1, 32'h0000_0080, "l1_rd80");
    drive(1, 1, 0, 32'h0000_0080, 64'd0);
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_r = (k <= 4) || (k >= 7);
      chk($sformatf("l1_hold_resp_c%0d", k), 64'(if1.bmem_resp), 64'(exp_r));
      if (k <= 4)
        chk($sformatf("l1_hold_rdata_c%0d", k), if1.bmem_rdata, model1[4][64*(k-1) +: 64]);
      if (k >= 7)
        chk($sformatf("l1_hold_rdata_c%0d", k), if1.bmem_rdata, model1[4][64*(k-7) +: 64]);
      @(posedge clk); #1;
      if (k == 10) drive(1, 0, 0, 32'h0000_0080, 64'd0);
    end
    @(negedge clk);
    chk("l1_done_resp", 64'(if1.bmem_resp), 64'd0);
    chk("l1_perr", 64'(perr1), 64'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
